cic_decimator_pdm: RTL



---
 rtl/cic_pkg.sv | 22 ++
 rtl/cic_scale_sat.sv | 38 +++
 rtl/cic_decimator_pdm.sv | 97 +++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared sizing helpers for the PDM CIC decimator: internal width, output shift,
// settle-count load value and rate-select to log2(R) mapping.
package cic_pkg;

  function automatic int cic_width(input int stages, input int log2_rmax);
    return 1 + stages * log2_rmax;
  endfunction

  // Positive result: right shift; zero or negative: left shift by the magnitude.
  function automatic int cic_shift(input int stages, input int k, input int out_width);
    return stages * k - out_width;
  endfunction

  function automatic int settle_init(input int stages);
    return stages + 1;
  endfunction

  function automatic int rate_to_k(input int log2_rmax, input logic [1:0] rate_sel);
    return log2_rmax - int'(rate_sel);
  endfunction

endpackage

// File: rtl/cic_scale_sat.sv
// Combinational output scaling for the CIC decimator: shift by N*k - OUT_WIDTH,
// then saturate. Round-half-up before right shifts when CIC_ROUND_EN is defined.
module cic_scale_sat
  import cic_pkg::*;
#(
  parameter int W         = 13,
  parameter int KW        = 3,
  parameter int STAGES    = 3,
  parameter int OUT_WIDTH = 8
) (
  input  logic [W-1:0]         comb_out,
  input  logic [KW-1:0]        k,
  output logic [OUT_WIDTH-1:0] dout
);

  // Headroom for both the rounding offset and the largest left shift.
  localparam int XW = W + OUT_WIDTH + 1;

  int            s;
  logic [XW-1:0] wide;
  logic [XW-1:0] shifted;

  always_comb begin
    s       = cic_shift(STAGES, int'(k), OUT_WIDTH);
    wide    = XW'(comb_out);
    shifted = wide;
    if (s > 0) begin
`ifdef CIC_ROUND_EN
      wide = wide + (XW'(1) << (s - 1));
`endif
      shifted = wide >> s;
    end else begin
      shifted = wide << (-s);
    end
    dout = (|shifted[XW-1:OUT_WIDTH]) ? '1 : shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/cic_decimator_pdm.sv
// N-stage CIC decimator for a 1-bit PDM stream with runtime ratio select,
// settling mask and output strobe. Optional rounding via CIC_ROUND_EN.
module cic_decimator_pdm
  import cic_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int LOG2_RMAX = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic [1:0]           rate_sel,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid
);

  localparam int W  = cic_width(STAGES, LOG2_RMAX);
  localparam int KW = $clog2(LOG2_RMAX + 1);
  localparam int SW = $clog2(STAGES + 2);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(settle_init(STAGES));

  logic [W-1:0]           integ [STAGES];
  logic [W-1:0]           z     [STAGES];
  logic [W-1:0]           comb  [STAGES];
  logic [LOG2_RMAX-1:0]   cnt;
  logic [LOG2_RMAX-1:0]   cnt_last;
  logic [1:0]             rate_q;
  logic [SW-1:0]          settle;
  logic [KW-1:0]          k;
  logic [OUT_WIDTH-1:0]   scaled;
  logic                   rate_change;
  logic                   dec;

  assign rate_change = (rate_sel != rate_q);
  // R-1 is all-ones over k bits, so shifting the full mask by rate_q gives it directly.
  assign cnt_last    = {LOG2_RMAX{1'b1}} >> rate_q;
  assign dec         = din_valid && !rate_change && (cnt == cnt_last);
  assign k           = KW'(rate_to_k(LOG2_RMAX, rate_q));

  always_comb begin
    comb[0] = integ[STAGES-1] - z[0];
    for (int j = 1; j < STAGES; j++) begin
      comb[j] = comb[j-1] - z[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) integ[i] <= '0;
    end else if (din_valid) begin
      integ[0] <= integ[0] + W'(din);
      for (int i = 1; i < STAGES; i++) integ[i] <= integ[i] + integ[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rate_q     <= '0;
      settle     <= SETTLE_LOAD;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int j = 0; j < STAGES; j++) z[j] <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (rate_change) begin
        rate_q <= rate_sel;
        cnt    <= '0;
        settle <= SETTLE_LOAD;
        for (int j = 0; j < STAGES; j++) z[j] <= '0;
      end else if (dec) begin
        cnt  <= '0;
        z[0] <= integ[STAGES-1];
        for (int j = 1; j < STAGES; j++) z[j] <= comb[j-1];
        dout <= scaled;
        if (settle == '0) dout_valid <= 1'b1;
        else              settle     <= settle - 1'b1;
      end else if (din_valid) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  cic_scale_sat #(
    .W         (W),
    .KW        (KW),
    .STAGES    (STAGES),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_scale (
    .comb_out (comb[STAGES-1]),
    .k        (k),
    .dout     (scaled)
  );

endmodule
